mc_bank_sched: RTL and testbench

Per-chip-select bank access sequencer that sits directly upstream of the open-bank/row tracker. It accepts one read/write request at a time and checks the tracker's `bank_open`, `row_same` and `any_bank_open` status. It then issues the SDRAM command sequence (PRE → ACT → RD/WR) with tRP/tRCD spacing, and drives the tracker's `bank_set`, `bank_clr` and `bank_clr_all` strobes. It also services precharge-all requests from the refresh/init logic.

---
 rtl/mc_sched_pkg.sv | 11 +
 rtl/mc_tcnt.sv | 19 +
 rtl/mc_bank_sched.sv | 82 ++++++++
 tb/tb_mc_bank_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_sched_pkg.sv
// mc_sched_pkg: shared state encoding, wait-counter width and timing-parameter limits
package mc_sched_pkg;
    localparam int CNT_W    = 4;
    localparam int TRCD_MIN = 1;
    localparam int TRCD_MAX = 15;
    localparam int TRP_MIN  = 1;
    localparam int TRP_MAX  = 15;
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_TRP_WAIT, S_ACT, S_TRCD_WAIT, S_ACCESS, S_PALL, S_PALL_WAIT
    } state_t;
endpackage

// File: rtl/mc_tcnt.sv
// mc_tcnt: loadable down-counter with zero flag; saturates at zero instead of wrapping
module mc_tcnt
    import mc_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && !zero) cnt <= cnt - 1'b1;
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/mc_bank_sched.sv
// mc_bank_sched: per-chip-select PRE/ACT/RD/WR sequencer with tRP/tRCD spacing,
// driving the open-bank tracker strobes and servicing precharge-all requests.
module mc_bank_sched
    import mc_sched_pkg::*;
#(
    parameter int TRCD = 2,
    parameter int TRP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [12:0] row_adr,
    input  logic [1:0]  bank_adr,
    output logic        ack,
    input  logic        prech_all_req,
    output logic        prech_all_done,
    input  logic        bank_open,
    input  logic        any_bank_open,
    input  logic        row_same,
    output logic        bank_set,
    output logic        bank_clr,
    output logic        bank_clr_all,
    output logic        cmd_act,
    output logic        cmd_pre,
    output logic        cmd_pall,
    output logic        cmd_rd,
    output logic        cmd_wr,
    output logic        busy
);
    if (TRCD < TRCD_MIN || TRCD > TRCD_MAX || TRP < TRP_MIN || TRP > TRP_MAX) begin : g_bad_param
        $error("mc_bank_sched: TRCD/TRP out of range");
    end
    state_t           state, nxt;
    logic             zero, load, dec;
    logic [CNT_W-1:0] load_val;
    logic             unused_adr;
    assign unused_adr = ^{row_adr, bank_adr};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else state <= nxt;
    end
    // Counter is preloaded on entry to each command state, so it already
    // reads zero in the command cycle when the parameter is 1.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:                 nxt = prech_all_req ? (any_bank_open ? S_PALL : S_PALL_WAIT) :
                                          !req ? S_IDLE : !bank_open ? S_ACT : row_same ? S_ACCESS : S_PRE;
            S_PRE, S_TRP_WAIT:      nxt = zero ? S_ACT : S_TRP_WAIT;
            S_ACT, S_TRCD_WAIT:     nxt = zero ? S_ACCESS : S_TRCD_WAIT;
            S_ACCESS:               nxt = S_IDLE;
            S_PALL, S_PALL_WAIT:    nxt = zero ? S_IDLE : S_PALL_WAIT;
            default:                nxt = S_IDLE;
        endcase
    end
    assign load     = state == S_IDLE || (nxt == S_ACT && state != S_ACT);
    assign dec      = state != S_IDLE && state != S_ACCESS;
    assign load_val = nxt == S_ACT ? CNT_W'(TRCD - 1) :
                      (nxt == S_PRE || nxt == S_PALL) ? CNT_W'(TRP - 1) : '0;
    mc_tcnt u_tcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .dec      (dec),
        .load_val (load_val),
        .zero     (zero)
    );
    always_comb begin
        busy           = state != S_IDLE;
        cmd_pre        = state == S_PRE;
        cmd_act        = state == S_ACT;
        cmd_pall       = state == S_PALL;
        ack            = state == S_ACCESS;
        cmd_rd         = ack && !req_we;
        cmd_wr         = ack && req_we;
        bank_clr       = cmd_pre;
        bank_set       = cmd_act;
        bank_clr_all   = cmd_pall;
        prech_all_done = (state == S_PALL || state == S_PALL_WAIT) && zero;
    end
endmodule

// File: tb/tb_mc_bank_sched.sv
// tb_mc_bank_sched: scoreboard bench for mc_bank_sched with a behavioural bank tracker
module tb_mc_bank_sched;
    localparam int TRCD = 2;
    localparam int TRP  = 3;
    // obs bit order: busy ack done set clr clr_all act pre pall rd wr
    localparam logic [10:0] E_IDLE = 11'h000;
    localparam logic [10:0] E_WAIT = 11'h400;
    localparam logic [10:0] E_ACT  = 11'h490;
    localparam logic [10:0] E_PRE  = 11'h448;
    localparam logic [10:0] E_PALL = 11'h424;
    localparam logic [10:0] E_RD   = 11'h602;
    localparam logic [10:0] E_WR   = 11'h601;
    localparam logic [10:0] E_DONE = 11'h500;
    logic        clk = 0, rst = 0, req = 0, req_we = 0, prech_all_req = 0;
    logic [12:0] row_adr = '0;
    logic [1:0]  bank_adr = '0;
    logic        ack, prech_all_done, bank_set, bank_clr, bank_clr_all;
    logic        cmd_act, cmd_pre, cmd_pall, cmd_rd, cmd_wr, busy;
    logic        bank_open, any_bank_open, row_same;
    logic [3:0]  t_open;
    logic [12:0] t_row [4];
    logic [10:0] obs;
    int          checks = 0, failures = 0;
    typedef struct {logic [10:0] vec; bit keep;} exp_t;
    exp_t sb[$];
    mc_bank_sched #(.TRCD(TRCD), .TRP(TRP)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .row_adr(row_adr),
        .bank_adr(bank_adr), .ack(ack), .prech_all_req(prech_all_req),
        .prech_all_done(prech_all_done), .bank_open(bank_open),
        .any_bank_open(any_bank_open), .row_same(row_same), .bank_set(bank_set),
        .bank_clr(bank_clr), .bank_clr_all(bank_clr_all), .cmd_act(cmd_act),
        .cmd_pre(cmd_pre), .cmd_pall(cmd_pall), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr),
        .busy(busy)
    );
    always #5 clk = ~clk;
    assign obs = {busy, ack, prech_all_done, bank_set, bank_clr, bank_clr_all,
                  cmd_act, cmd_pre, cmd_pall, cmd_rd, cmd_wr};
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_open <= '0;
            for (int i = 0; i < 4; i++) t_row[i] <= '0;
        end else if (bank_clr_all) t_open <= '0;
        else if (bank_clr) t_open[bank_adr] <= 1'b0;
        else if (bank_set) begin
            t_open[bank_adr] <= 1'b1;
            t_row[bank_adr]  <= row_adr;
        end
    end
    assign bank_open     = t_open[bank_adr];
    assign any_bank_open = |t_open;
    assign row_same      = t_row[bank_adr] == row_adr;
    task automatic push(input logic [10:0] v, input bit keep = 0);
        exp_t e;
        e.vec  = v;
        e.keep = keep;
        sb.push_back(e);
    endtask
    task automatic start_req(input logic we, input logic [1:0] b, input logic [12:0] r);
        req_we = we; bank_adr = b; row_adr = r; req = 1;
    endtask
    task automatic test_reset;
        #12;
        checks++;
        if (obs !== E_IDLE) begin failures++; $display("FAIL reset_hold got=%h exp=%h", obs, E_IDLE); end
        @(negedge clk) rst = 1;
        @(negedge clk);
        checks++;
        if (obs !== E_IDLE) begin failures++; $display("FAIL reset_idle got=%h exp=%h", obs, E_IDLE); end
    endtask
    task automatic test_closed_bank;
        exp_t e;
        int   c = 0;
        start_req(0, 2'd1, 13'h0AB);
        push(E_ACT); push(E_WAIT); push(E_RD); push(E_IDLE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            c++; checks++;
            if (obs !== e.vec) begin failures++; $display("FAIL closed_bank cyc%0d got=%h exp=%h", c, obs, e.vec); end
            if (e.vec[9] && !e.keep) req = 0;
        end
    endtask
    task automatic test_hit;
        exp_t e;
        int   c = 0;
        start_req(1, 2'd1, 13'h0AB);
        push(E_WR); push(E_IDLE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            c++; checks++;
            if (obs !== e.vec) begin failures++; $display("FAIL hit cyc%0d got=%h exp=%h", c, obs, e.vec); end
            if (e.vec[9] && !e.keep) req = 0;
        end
    endtask
    task automatic test_back_to_back;
        exp_t e;
        int   c = 0;
        start_req(0, 2'd1, 13'h0AB);
        push(E_RD, 1); push(E_IDLE); push(E_RD); push(E_IDLE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            c++; checks++;
            if (obs !== e.vec) begin failures++; $display("FAIL back_to_back cyc%0d got=%h exp=%h", c, obs, e.vec); end
            if (e.vec[9] && !e.keep) req = 0;
        end
    endtask
    task automatic test_row_miss;
        exp_t e;
        int   c = 0;
        start_req(0, 2'd1, 13'h0AC);
        push(E_PRE); push(E_WAIT); push(E_WAIT); push(E_ACT); push(E_WAIT); push(E_RD); push(E_IDLE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            c++; checks++;
            if (obs !== e.vec) begin failures++; $display("FAIL row_miss cyc%0d got=%h exp=%h", c, obs, e.vec); end
            if (e.vec[9] && !e.keep) req = 0;
        end
    endtask
    task automatic test_priority;
        exp_t e;
        int   c = 0;
        start_req(0, 2'd1, 13'h0AC);
        prech_all_req = 1;
        push(E_PALL); push(E_WAIT); push(E_DONE); push(E_IDLE);
        push(E_ACT); push(E_WAIT); push(E_RD); push(E_IDLE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            c++; checks++;
            if (obs !== e.vec) begin failures++; $display("FAIL priority cyc%0d got=%h exp=%h", c, obs, e.vec); end
            if (e.vec[9] && !e.keep) req = 0;
            if (e.vec[8]) prech_all_req = 0;
        end
    endtask
    task automatic test_pall_open;
        exp_t e;
        int   c = 0;
        prech_all_req = 1;
        push(E_PALL); push(E_WAIT); push(E_DONE); push(E_IDLE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            c++; checks++;
            if (obs !== e.vec) begin failures++; $display("FAIL pall_open cyc%0d got=%h exp=%h", c, obs, e.vec); end
            if (e.vec[8]) prech_all_req = 0;
        end
    endtask
    task automatic test_pall_none;
        exp_t e;
        int   c = 0;
        prech_all_req = 1;
        push(E_DONE); push(E_IDLE); push(E_IDLE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            c++; checks++;
            if (obs !== e.vec) begin failures++; $display("FAIL pall_none cyc%0d got=%h exp=%h", c, obs, e.vec); end
            if (e.vec[8]) prech_all_req = 0;
        end
    endtask
    task automatic test_reset_mid;
        start_req(0, 2'd2, 13'h123);
        @(negedge clk);
        checks++;
        if (obs !== E_ACT) begin failures++; $display("FAIL mid_act got=%h exp=%h", obs, E_ACT); end
        @(negedge clk);
        checks++;
        if (obs !== E_WAIT) begin failures++; $display("FAIL mid_trcd_wait got=%h exp=%h", obs, E_WAIT); end
        #1 rst = 0;
        #1;
        checks++;
        if (obs !== E_IDLE) begin failures++; $display("FAIL mid_reset_now got=%h exp=%h", obs, E_IDLE); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== E_IDLE) begin failures++; $display("FAIL mid_reset_hold%0d got=%h exp=%h", i, obs, E_IDLE); end
        end
        req = 0;
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== E_IDLE) begin failures++; $display("FAIL mid_after_release%0d got=%h exp=%h", i, obs, E_IDLE); end
        end
    endtask
    initial begin
        test_reset;
        test_closed_bank;
        test_hit;
        test_back_to_back;
        test_row_miss;
        test_priority;
        test_pall_open;
        test_pall_none;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
